// File: rtl/lane_pipe_array.sv
// Multi-lane elastic register pipeline: NUM_LANES independent valid/ready lanes,
// each DEPTH stages deep with bubble collapsing and a per-lane occupancy count.

module lane_pipe_lane #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    occupancy
);
   logic [DEPTH-1:0]            v;
   logic [DEPTH-1:0]            adv;
   logic [DEPTH-1:0][WIDTH-1:0] d;
   logic [CW-1:0]               occ;
   logic                        in_fire;
   logic                        out_fire;

   // A stage may advance if it or any stage after it is empty, or the sink takes a word.
   always_comb begin
      logic acc;
      acc = out_ready;
      adv = '0;
      for (int s = DEPTH-1; s >= 0; s--) begin
         acc    = acc | ~v[s];
         adv[s] = acc;
      end
   end

   assign in_ready  = adv[0] & ~flush;
   assign out_valid = v[DEPTH-1] & ~flush;
   assign out_data  = d[DEPTH-1];
   assign occupancy = occ;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v   <= '0;
         d   <= '0;
         occ <= '0;
      end else if (flush) begin
         v   <= '0;
         occ <= '0;
      end else begin
         if (adv[0]) begin
            v[0] <= in_valid;
            if (in_valid) d[0] <= in_data;
         end
         for (int s = 1; s < DEPTH; s++) begin
            if (adv[s]) begin
               v[s] <= v[s-1];
               if (v[s-1]) d[s] <= d[s-1];
            end
         end
         if (in_fire && !out_fire)
            occ <= occ + CW'(1);
         else if (!in_fire && out_fire)
            occ <= occ - CW'(1);
      end
   end
endmodule

module lane_pipe_array #(
   parameter int NUM_LANES = 4,
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 2,
   localparam int CW       = $clog2(DEPTH+1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NUM_LANES-1:0]       in_valid,
   output logic [NUM_LANES-1:0]       in_ready,
   input  logic [NUM_LANES*WIDTH-1:0] in_data,
   output logic [NUM_LANES-1:0]       out_valid,
   input  logic [NUM_LANES-1:0]       out_ready,
   output logic [NUM_LANES*WIDTH-1:0] out_data,
   output logic [NUM_LANES*CW-1:0]    occupancy
);
   genvar i;
   generate
      for (i = 0; i < NUM_LANES; i++) begin : g_lane
         lane_pipe_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CW    (CW)
         ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid[i]),
            .in_ready  (in_ready[i]),
            .in_data   (in_data[i*WIDTH +: WIDTH]),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH]),
            .occupancy (occupancy[i*CW +: CW])
         );
      end
   endgenerate
endmodule

// File: tb/tb_lane_pipe_array.sv
// Directed bench for lane_pipe_array (4 lanes, 8 bits, depth 2).
module tb_lane_pipe_array;
   logic        clk;
   logic        rst;
   logic        flush;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [31:0] in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;
   logic [7:0]  occupancy;

   int total  = 0;
   int passed = 0;

   lane_pipe_array #(.NUM_LANES(4), .WIDTH(8), .DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] od(input int l);
      return out_data[l*8 +: 8];
   endfunction

   function automatic logic [1:0] oc(input int l);
      return occupancy[l*2 +: 2];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // 1: reset with random inputs
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = 4'($urandom);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data",  out_data,       32'h0);
      chk("rst_occ",       32'(occupancy), 32'h0);
      rst       = 1'b0;
      in_valid  = 4'h0;
      out_ready = 4'hF;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'hF);

      // 2: streaming on lane 0
      @(negedge clk);
      in_valid = 4'b0001; in_data = 32'h11;
      #1 chk("s_rdy0", 32'(in_ready[0]), 32'h1);
      step();
      in_data = 32'h22;
      #1 chk("s_ov_early", 32'(out_valid[0]), 32'h0);
      chk("s_occ1", 32'(oc(0)), 32'h1);
      step();
      in_data = 32'h33;
      #1 chk("s_ov_11", 32'(out_valid[0]), 32'h1);
      chk("s_od_11", 32'(od(0)), 32'h11);
      chk("s_occ2a", 32'(oc(0)), 32'h2);
      step();
      in_valid = 4'b0000;
      #1 chk("s_od_22", 32'(od(0)), 32'h22);
      chk("s_occ2b", 32'(oc(0)), 32'h2);
      step();
      #1 chk("s_od_33", 32'(od(0)), 32'h33);
      chk("s_occ1b", 32'(oc(0)), 32'h1);
      step();
      #1 chk("s_ov_empty", 32'(out_valid[0]), 32'h0);
      chk("s_od_hold", 32'(od(0)), 32'h33);
      chk("s_occ0", 32'(oc(0)), 32'h0);

      // 3: back-pressure on lane 2
      out_ready = 4'b1011;
      in_valid  = 4'b0100; in_data = 32'h00A1_0000;
      #1 chk("bp_rdy_a1", 32'(in_ready[2]), 32'h1);
      step();
      in_data = 32'h00A2_0000;
      #1 chk("bp_rdy_a2", 32'(in_ready[2]), 32'h1);
      chk("bp_occ1", 32'(oc(2)), 32'h1);
      step();
      in_data = 32'h00A3_0000;
      #1 chk("bp_rdy_full", 32'(in_ready[2]), 32'h0);
      chk("bp_occ2", 32'(oc(2)), 32'h2);
      chk("bp_od_a1", 32'(od(2)), 32'hA1);
      step();
      #1 chk("bp_hold_occ", 32'(oc(2)), 32'h2);
      chk("bp_hold_od", 32'(od(2)), 32'hA1);
      out_ready = 4'hF;
      #1 chk("bp_rel_rdy", 32'(in_ready[2]), 32'h1);
      step();
      in_valid = 4'b0000;
      #1 chk("bp_od_a2", 32'(od(2)), 32'hA2);
      chk("bp_occ2b", 32'(oc(2)), 32'h2);
      step();
      #1 chk("bp_od_a3", 32'(od(2)), 32'hA3);
      chk("bp_occ1b", 32'(oc(2)), 32'h1);
      step();
      #1 chk("bp_empty", 32'(out_valid[2]), 32'h0);

      // 4: lane 1 stalled while the others stream
      out_ready = 4'b1101;
      in_valid  = 4'hF;
      for (int k = 0; k < 4; k++) begin
         in_data = {8'(8'h70 + k), 8'(8'h60 + k), 8'(8'h50 + k), 8'(8'h40 + k)};
         #1 chk("li_rdy1", 32'(in_ready[1]), (k < 2) ? 32'h1 : 32'h0);
         chk("li_rdy_oth", 32'(in_ready & 4'b1101), 32'hD);
         if (k >= 2) begin
            chk("li_ov_oth", 32'(out_valid & 4'b1101), 32'hD);
            chk("li_od0", 32'(od(0)), 32'(8'h40 + k - 2));
            chk("li_od2", 32'(od(2)), 32'(8'h60 + k - 2));
            chk("li_od3", 32'(od(3)), 32'(8'h70 + k - 2));
         end
         step();
      end
      in_valid = 4'h0;
      #1 chk("li_od1_hold", 32'(od(1)), 32'h50);
      chk("li_occ1", 32'(oc(1)), 32'h2);
      out_ready = 4'hF;
      step();
      #1 chk("li_od1_51", 32'(od(1)), 32'h51);
      step();
      #1 chk("li_l1_empty", 32'(out_valid[1]), 32'h0);
      step();

      // 5: lane 3 full, simultaneous accept and emit
      out_ready = 4'b0111;
      in_valid  = 4'b1000; in_data = 32'hC100_0000;
      step();
      in_data = 32'hC200_0000;
      step();
      in_data = 32'hC300_0000;
      #1 chk("fs_occ_full", 32'(oc(3)), 32'h2);
      chk("fs_rdy_full", 32'(in_ready[3]), 32'h0);
      out_ready = 4'hF;
      for (int k = 0; k < 3; k++) begin
         in_data = {8'(8'hC3 + k), 24'h0};
         #1 chk("fs_rdy", 32'(in_ready[3]), 32'h1);
         chk("fs_od", 32'(od(3)), 32'(8'hC1 + k));
         chk("fs_occ", 32'(oc(3)), 32'h2);
         step();
      end
      in_valid  = 4'h0;
      out_ready = 4'h0;
      #1 chk("fs_od_c4", 32'(od(3)), 32'hC4);
      chk("fs_occ_end", 32'(oc(3)), 32'h2);

      // 6a: flush with lanes 0 and 3 full
      in_valid = 4'b0001; in_data = 32'hD1;
      step();
      in_data = 32'hD2;
      step();
      in_valid = 4'h0;
      #1 chk("fl_pre_occ", 32'(occupancy), 32'h82);
      in_valid  = 4'hF;
      out_ready = 4'hF;
      flush     = 1'b1;
      #1 chk("fl_in_ready", 32'(in_ready), 32'h0);
      chk("fl_out_valid", 32'(out_valid), 32'h0);
      step();
      flush    = 1'b0;
      in_valid = 4'h0;
      #1 chk("fl_ov_after", 32'(out_valid), 32'h0);
      chk("fl_occ_after", 32'(occupancy), 32'h0);
      chk("fl_rdy_after", 32'(in_ready), 32'hF);
      chk("fl_data_kept", 32'(od(3)), 32'hC4);

      // 6b: async reset pulse between edges with lanes 0 and 3 full
      out_ready = 4'h0;
      in_valid  = 4'b1001; in_data = 32'hF100_00E1;
      step();
      in_data = 32'hF200_00E2;
      step();
      in_valid = 4'h0;
      #1 chk("ar_pre_occ", 32'(occupancy), 32'h82);
      chk("ar_pre_ov", 32'(out_valid), 32'h9);
      #1 rst = 1'b1;
      #1 chk("ar_ov", 32'(out_valid), 32'h0);
      chk("ar_occ", 32'(occupancy), 32'h0);
      chk("ar_od", out_data, 32'h0);
      rst = 1'b0;
      #1 chk("ar_rdy", 32'(in_ready), 32'hF);
      step();
      #1 chk("ar_occ_next", 32'(occupancy), 32'h0);
      chk("ar_ov_next", 32'(out_valid), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
